// File: rtl/multicycle_ctrl.sv
// Control sequencer for a multicycle MIPS datapath (R-type, LW, SW, BEQ, ADDI, J).
// Outputs are decoded combinationally from the current state; state and instret are flopped.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [5:0]       i_op,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_pcen,
    output logic             o_iord,
    output logic             o_memread,
    output logic             o_memwrite,
    output logic             o_irwrite,
    output logic             o_regdst,
    output logic             o_memtoreg,
    output logic             o_regwrite,
    output logic             o_alusrca,
    output logic [1:0]       o_alusrcb,
    output logic [1:0]       o_pcsrc,
    output logic [1:0]       o_aluop,
    output logic             o_illegal_op,
    output logic [3:0]       o_state,
    output logic [CNT_W-1:0] o_instret
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    state_e           r_state;
    state_e           w_state_next;
    logic             w_retire;
    logic             w_pcwrite;
    logic             w_branch;
    logic [CNT_W-1:0] r_instret;

    always_comb begin
        w_state_next = StFetch;
        w_retire     = 1'b0;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        o_iord       = 1'b0;
        o_memread    = 1'b0;
        o_memwrite   = 1'b0;
        o_irwrite    = 1'b0;
        o_regdst     = 1'b0;
        o_memtoreg   = 1'b0;
        o_regwrite   = 1'b0;
        o_alusrca    = 1'b0;
        o_alusrcb    = 2'b00;
        o_pcsrc      = 2'b00;
        o_aluop      = 2'b00;
        o_illegal_op = 1'b0;
        case (r_state)
            StFetch: begin
                // FETCH is the reset state, so its requests are gated while reset is held
                o_memread = i_reset_n;
                o_alusrcb = 2'b01;
                o_irwrite = i_mem_ready & i_reset_n;
                w_pcwrite = i_mem_ready & i_reset_n;
                w_state_next = i_mem_ready ? StDecode : StFetch;
            end
            StDecode: begin
                o_alusrcb = 2'b11;
                case (i_op)
                    OpLw, OpSw: w_state_next = StMemAdr;
                    OpRtype:    w_state_next = StExecute;
                    OpBeq:      w_state_next = StBranch;
                    OpAddi:     w_state_next = StAddiEx;
                    OpJ:        w_state_next = StJump;
                    default: begin
                        o_illegal_op = 1'b1;
                        w_state_next = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                o_alusrca    = 1'b1;
                o_alusrcb    = 2'b10;
                w_state_next = (i_op == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                o_iord       = 1'b1;
                o_memread    = 1'b1;
                w_state_next = i_mem_ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                o_memtoreg = 1'b1;
                o_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            StMemWr: begin
                o_iord       = 1'b1;
                o_memwrite   = 1'b1;
                w_retire     = i_mem_ready;
                w_state_next = i_mem_ready ? StFetch : StMemWr;
            end
            StExecute: begin
                o_alusrca    = 1'b1;
                o_aluop      = 2'b10;
                w_state_next = StAluWb;
            end
            StAluWb: begin
                o_regdst   = 1'b1;
                o_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            StBranch: begin
                o_alusrca = 1'b1;
                o_aluop   = 2'b01;
                o_pcsrc   = 2'b01;
                w_branch  = 1'b1;
                w_retire  = 1'b1;
            end
            StAddiEx: begin
                o_alusrca    = 1'b1;
                o_alusrcb    = 2'b10;
                w_state_next = StAddiWb;
            end
            StAddiWb: begin
                o_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            StJump: begin
                o_pcsrc   = 2'b10;
                w_pcwrite = 1'b1;
                w_retire  = 1'b1;
            end
            default: w_state_next = StFetch;
        endcase
        o_pcen = w_pcwrite | (w_branch & i_zero);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= StFetch;
            r_instret <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_retire) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    assign o_state   = r_state;
    assign o_instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: inputs change and outputs are sampled just after
// each falling edge, so every check sees one settled cycle of the sequencer.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset_n;
    logic [5:0]  op;
    logic        zero;
    logic        mem_ready;
    logic        pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]  alusrcb, pcsrc, aluop;
    logic        illegal_op;
    logic [3:0]  state;
    logic [31:0] instret;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_ctrl #(.CNT_W(32)) u_dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_op         (op),
        .i_zero       (zero),
        .i_mem_ready  (mem_ready),
        .o_pcen       (pcen),
        .o_iord       (iord),
        .o_memread    (memread),
        .o_memwrite   (memwrite),
        .o_irwrite    (irwrite),
        .o_regdst     (regdst),
        .o_memtoreg   (memtoreg),
        .o_regwrite   (regwrite),
        .o_alusrca    (alusrca),
        .o_alusrcb    (alusrcb),
        .o_pcsrc      (pcsrc),
        .o_aluop      (aluop),
        .o_illegal_op (illegal_op),
        .o_state      (state),
        .o_instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs for the current cycle and let combinational outputs settle.
    task automatic drive(input logic [5:0] o, input logic z, input logic mr);
        op        = o;
        zero      = z;
        mem_ready = mr;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        op        = 6'b0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_instret", instret, 32'd0);
        check("rst_memread", 32'(memread), 32'd0);
        check("rst_pcen", 32'(pcen), 32'd0);
        check("rst_irwrite", 32'(irwrite), 32'd0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;

        // LW, memory always ready
        drive(6'b100011, 1'b0, 1'b1);
        check("lw_fetch_state", 32'(state), 32'd0);
        check("lw_fetch_rd", 32'({memread, irwrite, pcen, iord}), 32'b1110);
        check("lw_fetch_srcb", 32'(alusrcb), 32'd1);
        next_cycle(); drive(6'b100011, 1'b0, 1'b1);
        check("lw_decode_state", 32'(state), 32'd1);
        check("lw_decode_srcb", 32'(alusrcb), 32'd3);
        next_cycle(); drive(6'b100011, 1'b0, 1'b1);
        check("lw_memadr_state", 32'(state), 32'd2);
        check("lw_memadr_src", 32'({alusrca, alusrcb}), 32'b110);
        next_cycle(); drive(6'b100011, 1'b0, 1'b1);
        check("lw_memrd_state", 32'(state), 32'd3);
        check("lw_memrd_ctl", 32'({iord, memread, regwrite}), 32'b110);
        next_cycle(); drive(6'b100011, 1'b0, 1'b1);
        check("lw_memwb_state", 32'(state), 32'd4);
        check("lw_memwb_ctl", 32'({regwrite, memtoreg, regdst}), 32'b110);
        check("lw_instret_pre", instret, 32'd0);
        next_cycle(); drive(6'b000100, 1'b1, 1'b1);
        check("lw_done_state", 32'(state), 32'd0);
        check("lw_instret", instret, 32'd1);

        // BEQ taken, then BEQ not taken
        for (int i = 0; i < 2; i++) begin
            next_cycle(); drive(6'b000100, (i == 0), 1'b1);
            check("beq_decode", 32'(state), 32'd1);
            next_cycle(); drive(6'b000100, (i == 0), 1'b1);
            check("beq_state", 32'(state), 32'd8);
            check("beq_ctl", 32'({pcen, pcsrc, aluop, regwrite}), (i == 0) ? 32'b101010 : 32'b001010);
            next_cycle(); drive(6'b101011, 1'b0, 1'b1);
            check("beq_done", 32'(state), 32'd0);
        end
        check("beq_instret", instret, 32'd3);

        // SW with three wait cycles in MEMWR
        next_cycle(); drive(6'b101011, 1'b0, 1'b1);
        check("sw_decode", 32'(state), 32'd1);
        next_cycle(); drive(6'b101011, 1'b0, 1'b1);
        check("sw_memadr", 32'(state), 32'd2);
        for (int i = 0; i < 4; i++) begin
            next_cycle(); drive(6'b101011, 1'b0, (i == 3));
            check("sw_memwr_state", 32'(state), 32'd5);
            check("sw_memwr_ctl", 32'({memwrite, iord, memread}), 32'b110);
        end
        next_cycle(); drive(6'b000000, 1'b0, 1'b0);
        check("sw_done", 32'(state), 32'd0);
        check("sw_instret", instret, 32'd4);

        // FETCH stalls two cycles, then an R-type
        check("fw_wait0", 32'({memread, irwrite, pcen}), 32'b100);
        next_cycle(); drive(6'b000000, 1'b0, 1'b0);
        check("fw_wait1_state", 32'(state), 32'd0);
        check("fw_wait1", 32'({memread, irwrite, pcen}), 32'b100);
        next_cycle(); drive(6'b000000, 1'b0, 1'b1);
        check("fw_ready", 32'({memread, irwrite, pcen}), 32'b111);
        next_cycle(); drive(6'b000000, 1'b0, 1'b1);
        check("r_decode", 32'(state), 32'd1);
        next_cycle(); drive(6'b000000, 1'b0, 1'b1);
        check("r_exec", 32'({state, alusrca, alusrcb, aluop}), {23'd0, 4'd6, 1'b1, 2'b00, 2'b10});
        next_cycle(); drive(6'b111111, 1'b0, 1'b1);
        check("r_aluwb", 32'({state, regdst, memtoreg, regwrite}), {25'd0, 4'd7, 3'b101});
        next_cycle(); drive(6'b111111, 1'b0, 1'b1);
        check("r_instret", instret, 32'd5);

        // Illegal opcode
        next_cycle(); drive(6'b111111, 1'b0, 1'b1);
        check("ill_decode", 32'({state, illegal_op, regwrite, memwrite}), {25'd0, 4'd1, 3'b100});
        next_cycle(); drive(6'b001000, 1'b0, 1'b1);
        check("ill_back", 32'({state, illegal_op}), {27'd0, 4'd0, 1'b0});
        check("ill_instret", instret, 32'd5);

        // ADDI
        next_cycle(); drive(6'b001000, 1'b0, 1'b1);
        next_cycle(); drive(6'b001000, 1'b0, 1'b1);
        check("addi_ex", 32'({state, alusrca, alusrcb}), {25'd0, 4'd9, 3'b110});
        next_cycle(); drive(6'b101011, 1'b0, 1'b1);
        check("addi_wb", 32'({state, regdst, regwrite}), {26'd0, 4'd10, 2'b01});
        next_cycle(); drive(6'b101011, 1'b0, 1'b1);
        check("addi_instret", instret, 32'd6);

        // Reset while SW waits in MEMWR
        next_cycle(); drive(6'b101011, 1'b0, 1'b1);
        next_cycle(); drive(6'b101011, 1'b0, 1'b0);
        next_cycle(); drive(6'b101011, 1'b0, 1'b0);
        check("rmid_memwr", 32'({state, memwrite}), {27'd0, 4'd5, 1'b1});
        reset_n = 1'b0;
        #1;
        check("rmid_memwrite", 32'(memwrite), 32'd0);
        check("rmid_state", 32'(state), 32'd0);
        check("rmid_instret", instret, 32'd0);
        check("rmid_memread", 32'(memread), 32'd0);
        next_cycle();
        reset_n = 1'b1;
        drive(6'b000010, 1'b0, 1'b1);
        check("j_fetch", 32'({state, irwrite, pcen}), {26'd0, 4'd0, 2'b11});
        next_cycle(); drive(6'b000010, 1'b0, 1'b1);
        check("j_decode", 32'(state), 32'd1);
        next_cycle(); drive(6'b000010, 1'b0, 1'b1);
        check("j_jump", 32'({state, pcen, pcsrc}), {25'd0, 4'd11, 3'b110});
        next_cycle(); drive(6'b000010, 1'b0, 1'b1);
        check("j_done", 32'(state), 32'd0);
        check("j_instret", instret, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
